mips_boot_loader: RTL and testbench

Upstream loader for the single-cycle MIPS core. It receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them into the instruction RAM's write port. It holds the core in reset until a complete, verified image has been written. Its outputs drive the instruction memory write port and the core's `rst` input.

---
 rtl/mips_boot_loader.sv | 238 +++++++++++++++++++++++
 tb/tb_mips_boot_loader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_boot_loader.sv
// ---------------------------------------------------------------------------
// mips_boot_loader
//
// Purpose:
//    Upstream loader for the single-cycle MIPS core. It receives a byte
//    stream over a valid/ready handshake and assembles big-endian 32-bit
//    words. It writes those words into the instruction RAM write port, and
//    it holds the core in reset until a complete image has been written.
//
//    Stream: length high byte, length low byte (word count N), then N x 4
//    data bytes, each word most-significant byte first. When the
//    BOOT_CHECKSUM_EN macro is defined, one trailing checksum byte follows.
//    That byte must equal the XOR of every byte before it.
//
// Configuration macro:
//    BOOT_CHECKSUM_EN - compiles in the CHECK state and the checksum logic.
//                       Without it, the loader enters DONE straight after
//                       the last data byte.
//
// Parameters:
//    DW - instruction word width (must be 32, four bytes per word)
//    AW - instruction RAM word-address width (capacity 2**AW words)
//
// Ports:
//    clk        in   system clock, rising edge
//    rst        in   synchronous active-high reset
//    start      in   begin a load (honoured only in IDLE, DONE, ERR)
//    rx_valid   in   input byte valid
//    rx_data    in   input byte
//    rx_ready   out  loader can accept a byte this cycle
//    imem_we    out  instruction RAM write enable (single-cycle pulse)
//    imem_addr  out  instruction RAM word address
//    imem_wdata out  instruction word
//    core_rst   out  reset to the MIPS core, low only in DONE
//    busy       out  load in progress
//    done       out  image loaded (sticky until start or rst)
//    err        out  load failed (sticky until start or rst)
// ---------------------------------------------------------------------------
module mips_boot_loader #(
   parameter int DW = 32,
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          rx_valid,
   input  logic [7:0]    rx_data,
   output logic          rx_ready,
   output logic          imem_we,
   output logic [AW-1:0] imem_addr,
   output logic [DW-1:0] imem_wdata,
   output logic          core_rst,
   output logic          busy,
   output logic          done,
   output logic          err
);

   // Largest legal word count. It is 17 bits wide so that AW = 16 still fits.
   localparam logic [16:0] MAX_WORDS = 17'(2 ** AW);

`ifdef BOOT_CHECKSUM_EN
   typedef enum logic [2:0] {
      IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERR
   } state_t;
   // After the last data byte, the checksum byte is still outstanding.
   localparam state_t LOAD_END = CHECK;
`else
   typedef enum logic [2:0] {
      IDLE, LEN_HI, LEN_LO, DATA, DONE, ERR
   } state_t;
   localparam state_t LOAD_END = DONE;
`endif

   state_t      state;
   state_t      state_next;

   logic [7:0]  len_hi;
   logic [15:0] length;
   logic [15:0] length_in;
   logic [15:0] word_cnt;
   logic [15:0] word_cnt_inc;
   logic [1:0]  byte_cnt;
   logic [23:0] word_sr;
   logic        accept;
   logic        start_load;
   logic        word_byte_last;

`ifdef BOOT_CHECKSUM_EN
   logic [7:0]  checksum;
`endif

   // The length is complete once the low byte arrives, so decisions in
   // LEN_LO use the incoming byte directly rather than a registered copy.
   assign length_in      = {len_hi, rx_data};
   assign word_cnt_inc   = word_cnt + 16'd1;
   assign word_byte_last = (byte_cnt == 2'd3);

   // busy covers every state that consumes stream bytes.
   always_comb begin
      busy = 1'b0;
      case (state)
         LEN_HI, LEN_LO, DATA: busy = 1'b1;
`ifdef BOOT_CHECKSUM_EN
         CHECK:                busy = 1'b1;
`endif
         default:              busy = 1'b0;
      endcase
   end

   // The cycle in which a word is written is a deliberate bubble. Holding
   // ready low there keeps the write and the next byte from overlapping.
   assign rx_ready = busy & ~imem_we;
   assign accept   = rx_valid & rx_ready;
   assign done     = (state == DONE);
   assign err      = (state == ERR);
   assign core_rst = (state != DONE);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. start_load marks the single cycle in which a new load
   // is accepted, so that the datapath can clear its counters.
   always_comb begin
      state_next = state;
      start_load = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = LEN_HI;
               start_load = 1'b1;
            end
         end
         LEN_HI: begin
            if (accept) begin
               state_next = LEN_LO;
            end
         end
         LEN_LO: begin
            if (accept) begin
               if ({1'b0, length_in} > MAX_WORDS) begin
                  state_next = ERR;
               end else if (length_in == 16'd0) begin
                  state_next = LOAD_END;
               end else begin
                  state_next = DATA;
               end
            end
         end
         DATA: begin
            if (accept && word_byte_last && (word_cnt_inc == length)) begin
               state_next = LOAD_END;
            end
         end
`ifdef BOOT_CHECKSUM_EN
         CHECK: begin
            if (accept) begin
               state_next = (rx_data == checksum) ? DONE : ERR;
            end
         end
`endif
         DONE, ERR: begin
            if (start) begin
               state_next = LEN_HI;
               start_load = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Word assembly and the instruction RAM write port. The first three bytes
   // of a word collect in word_sr. The fourth byte completes the word, and
   // the word is registered to imem_wdata together with a one-cycle write
   // pulse. The address advances in the write cycle, so that the write uses
   // the current address. The address holds at its top value instead of
   // wrapping, because a maximum-length image ends there.
   always_ff @(posedge clk) begin
      if (rst) begin
         len_hi     <= 8'h00;
         length     <= 16'h0000;
         word_cnt   <= 16'h0000;
         byte_cnt   <= 2'd0;
         word_sr    <= 24'h000000;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
      end else begin
         imem_we <= 1'b0;
         if (start_load) begin
            word_cnt  <= 16'h0000;
            byte_cnt  <= 2'd0;
            imem_addr <= '0;
         end else begin
            if (imem_we && (imem_addr != {AW{1'b1}})) begin
               imem_addr <= imem_addr + 1'b1;
            end
            if (accept) begin
               case (state)
                  LEN_HI: len_hi <= rx_data;
                  LEN_LO: length <= length_in;
                  DATA: begin
                     byte_cnt <= byte_cnt + 2'd1;
                     if (word_byte_last) begin
                        imem_wdata <= {word_sr, rx_data};
                        imem_we    <= 1'b1;
                        word_cnt   <= word_cnt_inc;
                     end else begin
                        word_sr <= {word_sr[15:0], rx_data};
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

`ifdef BOOT_CHECKSUM_EN
   // Running XOR over the length and data bytes. The checksum byte itself
   // arrives in CHECK, is compared against this value, and is not folded in.
   always_ff @(posedge clk) begin
      if (rst) begin
         checksum <= 8'h00;
      end else if (start_load) begin
         checksum <= 8'h00;
      end else if (accept && (state != CHECK)) begin
         checksum <= checksum ^ rx_data;
      end
   end
`endif

endmodule

// File: tb/tb_mips_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_mips_boot_loader
//
// Self-checking bench for mips_boot_loader (AW = 8). The bench takes a table
// of image loads. Each entry gives the word count, the first data words and
// the expected outcome. Every entry is streamed with random valid gaps, and
// the bench compares the done/err timing, the first write cycle, every RAM
// write and the final address. Hand-written sequences cover the reset
// values, start while busy, and reset in the middle of a word. The stream
// and the checksum byte follow BOOT_CHECKSUM_EN in the same way as the
// design.
// ---------------------------------------------------------------------------
module tb_mips_boot_loader;

   localparam int DW = 32;
   localparam int AW = 8;

`ifdef BOOT_CHECKSUM_EN
   localparam bit CSUM_ON = 1'b1;
`else
   localparam bit CSUM_ON = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic          start;
   logic          rx_valid;
   logic [7:0]    rx_data;
   logic          rx_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [DW-1:0] imem_wdata;
   logic          core_rst;
   logic          busy;
   logic          done;
   logic          err;

   int num_checks;
   int num_fail;

   // Record of every RAM write. The monitor process is the only writer.
   int            wr_count;
   logic [AW-1:0] wr_addr [0:1023];
   logic [DW-1:0] wr_data [0:1023];

   typedef struct {
      logic [15:0] n;
      logic [31:0] w0;
      logic [31:0] w1;
      logic [31:0] w2;
      bit          bad_sum;
      bit          len_only;
      bit          exp_err;
      int          exp_writes;
      logic [7:0]  exp_addr_end;
   } vec_t;

   vec_t vecs [0:6];

   mips_boot_loader #(.DW(DW), .AW(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_rst   (core_rst),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   // 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Capture each write pulse on the falling edge, mid-cycle.
   initial wr_count = 0;
   always @(negedge clk) begin
      if (imem_we) begin
         if (wr_count < 1024) begin
            wr_addr[wr_count] <= imem_addr;
            wr_data[wr_count] <= imem_wdata;
         end
         wr_count <= wr_count + 1;
      end
   end

   // Hard stop in case the bench ever hangs.
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got no end, expected end of test");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      num_checks++;
      if (actual !== expected) begin
         num_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Data word i of an image. The first three words come from the table, and
   // longer images use a fixed pattern derived from the index.
   function automatic logic [31:0] word_of(input vec_t v, input int i);
      logic [7:0] k;
      k = 8'(i);
      case (i)
         0:       return v.w0;
         1:       return v.w1;
         2:       return v.w2;
         default: return {k, ~k, k ^ 8'h5A, 8'hC3};
      endcase
   endfunction

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Offer one byte from a falling edge, wait (bounded) for ready, and
   // return at the falling edge after the transfer edge.
   task automatic send_byte(input logic [7:0] b, output bit ok);
      int wait_cycles;
      ok          = 1'b0;
      rx_data     = b;
      rx_valid    = 1'b1;
      wait_cycles = 0;
      while (!rx_ready && wait_cycles < 20) begin
         @(negedge clk);
         wait_cycles++;
      end
      if (rx_ready) begin
         @(posedge clk);
         ok = 1'b1;
      end
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   // Run one table entry from start to the end state, then check all writes.
   task automatic applyStimulus(input vec_t v);
      logic [7:0]  bytes [$];
      logic [7:0]  sum;
      logic [31:0] w;
      int          base;
      int          gap;
      bit          ok;

      bytes = {};
      bytes.push_back(v.n[15:8]);
      bytes.push_back(v.n[7:0]);
      if (!v.len_only) begin
         for (int i = 0; i < int'(v.n); i++) begin
            w = word_of(v, i);
            bytes.push_back(w[31:24]);
            bytes.push_back(w[23:16]);
            bytes.push_back(w[15:8]);
            bytes.push_back(w[7:0]);
         end
`ifdef BOOT_CHECKSUM_EN
         sum = 8'h00;
         foreach (bytes[i]) sum = sum ^ bytes[i];
         if (v.bad_sum) sum = sum ^ 8'h01;
         bytes.push_back(sum);
`endif
      end

      base = wr_count;
      pulse_start();
      checkOutput("start_busy", 32'(busy), 32'd1);
      checkOutput("start_clears_err", 32'(err), 32'd0);
      checkOutput("start_clears_done", 32'(done), 32'd0);
      checkOutput("start_core_rst", 32'(core_rst), 32'd1);

      for (int i = 0; i < bytes.size(); i++) begin
         gap = $urandom_range(0, 2);
         repeat (gap) @(negedge clk);
         if (i == bytes.size() - 1) begin
            checkOutput("pre_last_done", 32'(done), 32'd0);
            checkOutput("pre_last_err", 32'(err), 32'd0);
         end
         send_byte(bytes[i], ok);
         checkOutput("handshake", 32'(ok), 32'd1);
         // One cycle after the fourth byte of word 0, the write is visible.
         if (i == 5 && !v.len_only && v.n != 16'd0) begin
            checkOutput("first_we", 32'(imem_we), 32'd1);
            checkOutput("first_addr", 32'(imem_addr), 32'd0);
            checkOutput("first_wdata", imem_wdata, word_of(v, 0));
            checkOutput("bubble_ready", 32'(rx_ready), 32'd0);
         end
      end

      // One cycle after the final byte.
      checkOutput("end_done", 32'(done), 32'(!v.exp_err));
      checkOutput("end_err", 32'(err), 32'(v.exp_err));
      checkOutput("end_core_rst", 32'(core_rst), 32'(v.exp_err));
      checkOutput("end_busy", 32'(busy), 32'd0);

      repeat (3) @(negedge clk);
      checkOutput("sticky_done", 32'(done), 32'(!v.exp_err));
      checkOutput("sticky_err", 32'(err), 32'(v.exp_err));
      checkOutput("wr_count", 32'(wr_count - base), 32'(v.exp_writes));
      checkOutput("end_addr", 32'(imem_addr), 32'(v.exp_addr_end));
      for (int k = 0; k < v.exp_writes && (base + k) < 1024; k++) begin
         checkOutput("wr_addr", 32'(wr_addr[base + k]), 32'(k));
         checkOutput("wr_data", wr_data[base + k], word_of(v, k));
      end
   endtask

   initial begin
      bit ok;

      num_checks = 0;
      num_fail   = 0;

      // Table of loads: n, w0, w1, w2, bad_sum, len_only, exp_err,
      // exp_writes, exp_addr_end.
      vecs[0] = '{16'd2,   32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b0, 1'b0,    2,   8'd2};
      vecs[1] = '{16'd2,   32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0, CSUM_ON, 2,   8'd2};
      vecs[2] = '{16'd257, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b1,    0,   8'd0};
      vecs[3] = '{16'd0,   32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0,    0,   8'd0};
      vecs[4] = '{16'd3,   32'hDEADBEEF, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0,    3,   8'd3};
      vecs[5] = '{16'd256, 32'h0BADF00D, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0,    256, 8'd255};
      vecs[6] = '{16'd1,   32'hA5A55A5A, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0,    1,   8'd1};

      rst      = 1'b1;
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] reset values");
      checkOutput("rst_core_rst", 32'(core_rst), 32'd1);
      checkOutput("rst_rx_ready", 32'(rx_ready), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_we", 32'(imem_we), 32'd0);
      checkOutput("rst_addr", 32'(imem_addr), 32'd0);
      checkOutput("rst_wdata", imem_wdata, 32'd0);

      $display("[TB] table-driven loads");
      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i]);
      end

      $display("[TB] start while busy, then reset mid-word");
      pulse_start();
      send_byte(8'h00, ok);
      checkOutput("mid_handshake", 32'(ok), 32'd1);
      send_byte(8'h03, ok);
      send_byte(8'h11, ok);
      send_byte(8'h22, ok);
      send_byte(8'h33, ok);
      send_byte(8'h44, ok);
      checkOutput("mid_wdata", imem_wdata, 32'h11223344);
      pulse_start();
      checkOutput("mid_start_ignored_busy", 32'(busy), 32'd1);
      checkOutput("mid_start_ignored_addr", 32'(imem_addr), 32'd1);
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      send_byte(8'h55, ok);
      send_byte(8'h66, ok);
      pulse_reset();
      checkOutput("mid_rst_busy", 32'(busy), 32'd0);
      checkOutput("mid_rst_ready", 32'(rx_ready), 32'd0);
      checkOutput("mid_rst_core_rst", 32'(core_rst), 32'd1);
      checkOutput("mid_rst_addr", 32'(imem_addr), 32'd0);
      checkOutput("mid_rst_done", 32'(done), 32'd0);
      repeat (2) @(negedge clk);
      checkOutput("mid_rst_stays_idle", 32'(busy), 32'd0);

      // A fresh load after the reset must start again at address 0.
      applyStimulus(vecs[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
      $finish;
   end

endmodule
